// File: rtl/lsl8_seq_if.sv
// Request/result bundle for the iterative left shifter.
// The sequencer drives through the master modport; the shift unit uses the slave modport.
interface lsl8_seq_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = 3
);
    logic               start;
    logic [WIDTH-1:0]   d_in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   d_out;
    logic               carry;

    modport master (
        output start, d_in, shamt,
        input  busy, done, d_out, carry
    );

    modport slave (
        input  start, d_in, shamt,
        output busy, done, d_out, carry
    );
endinterface

// File: rtl/lsl8_seq.sv
// Multi-cycle logical shift-left unit: up to STEP_MAX positions per cycle.
// The result and the last bit shifted out are held until the next completion.
module lsl8_seq #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SHAMT_W  = 3,
    parameter int unsigned STEP_MAX = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    lsl8_seq_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               cbit_q, cbit_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               carry_q, carry_d;

    logic [SHAMT_W-1:0] step;
    logic [WIDTH:0]     shifted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            rem_q   <= '0;
            cbit_q  <= 1'b0;
            dout_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            rem_q   <= rem_d;
            cbit_q  <= cbit_d;
            dout_q  <= dout_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        rem_d   = rem_q;
        cbit_d  = cbit_q;
        dout_d  = dout_q;
        carry_d = carry_q;
        step    = (rem_q > SHAMT_W'(STEP_MAX)) ? SHAMT_W'(STEP_MAX) : rem_q;
        // Extra top bit captures the last bit pushed out of the MSB end.
        shifted = {1'b0, sreg_q} << step;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    sreg_d  = bus.d_in;
                    rem_d   = bus.shamt;
                    cbit_d  = 1'b0;
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                sreg_d = shifted[WIDTH-1:0];
                if (step != '0) begin
                    cbit_d = shifted[WIDTH];
                end
                rem_d = rem_q - step;
                if (rem_d == '0) begin
                    dout_d  = sreg_d;
                    carry_d = cbit_d;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy  = (state_q == StShift);
    assign bus.done  = (state_q == StDone);
    assign bus.d_out = dout_q;
    assign bus.carry = carry_q;
endmodule

// File: tb/tb_lsl8_seq.sv
// Scoreboard bench for lsl8_seq: expected results queued at issue, popped on done.
module tb_lsl8_seq;
    typedef struct {
        logic [7:0] dout;
        logic       carry;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic [7:0] prev_dout = 8'h00;
    logic       prev_carry = 1'b0;

    lsl8_seq_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

    lsl8_seq #(.WIDTH(8), .SHAMT_W(3), .STEP_MAX(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] d, input logic [2:0] s);
        exp_t e;
        logic [15:0] w;
        w       = {8'h00, d} << s;
        e.dout  = w[7:0];
        e.carry = (s != 3'd0) ? w[8] : 1'b0;
        e.lat   = (s == 3'd0) ? 1 : (int'(s) + 2) / 3;
        return e;
    endfunction

    // Called #1 after an edge; returns #1 after the edge where done is seen.
    task automatic run_op(input logic [7:0] d, input logic [2:0] s, input bit pulse_mid);
        exp_t e;
        int   n;
        bus.start = 1'b1;
        bus.d_in  = d;
        bus.shamt = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        sb_q.push_back(model(d, s));
        check_eq("accept_done_low", 32'(bus.done), 32'd0);
        n = 0;
        while (bus.done !== 1'b1 && n < 8) begin
            check_eq("busy_high", 32'(bus.busy), 32'd1);
            check_eq("dout_held", 32'(bus.d_out), 32'(prev_dout));
            check_eq("carry_held", 32'(bus.carry), 32'(prev_carry));
            if (pulse_mid && n == 0) begin
                bus.start = 1'b1;
                bus.d_in  = 8'h00;
                bus.shamt = 3'd0;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
        end
        if (bus.done !== 1'b1) begin
            check_eq("done_timeout", 32'(bus.done), 32'd1);
            sb_q.delete();
            return;
        end
        e = sb_q.pop_front();
        check_eq("latency", 32'(n), 32'(e.lat));
        check_eq("d_out", 32'(bus.d_out), 32'(e.dout));
        check_eq("carry", 32'(bus.carry), 32'(e.carry));
        check_eq("busy_at_done", 32'(bus.busy), 32'd0);
        prev_dout  = e.dout;
        prev_carry = e.carry;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.d_in  = 8'h00;
        bus.shamt = 3'd0;
        #2;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_dout", 32'(bus.d_out), 32'd0);
        check_eq("rst_carry", 32'(bus.carry), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Abort mid-shift: reset must clear outputs at once and suppress done.
        bus.start = 1'b1;
        bus.d_in  = 8'h3C;
        bus.shamt = 3'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_done", 32'(bus.done), 32'd0);
        check_eq("abort_dout", 32'(bus.d_out), 32'd0);
        check_eq("abort_carry", 32'(bus.carry), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("no_done_after_abort", 32'(bus.done), 32'd0);
        end

        run_op(8'hA5, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", 32'(bus.done), 32'd0);
        run_op(8'h81, 3'd1, 1'b0);
        run_op(8'hFF, 3'd7, 1'b1);
        run_op(8'h0F, 3'd4, 1'b0);
        // Back-to-back from the DONE cycle.
        run_op(8'h01, 3'd3, 1'b0);
        run_op(8'h80, 3'd7, 1'b0);
        run_op(8'h5A, 3'd6, 1'b1);

        for (int i = 0; i < 24; i++) begin
            if (($urandom & 1) != 0) begin
                @(posedge clk);
                #1;
            end
            run_op(8'($urandom), 3'($urandom_range(0, 7)), ($urandom & 1) != 0);
        end

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
